id_issue: RTL and testbench
===========================

Name: id_issue

Overview:
- Decode/issue stage that drives the execute stage's operand and operation inputs and writes the execute result back into a local register file.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them into an ALU operation code plus two 8-bit operands.
- Holds these on registered outputs for one execute cycle, then writes the returned result to the destination register.
- SHOW instructions also latch the result onto a display register for the board LEDs/7-seg.

Parameters:
- NREG, 4, number of 8-bit general registers (rd/rs field width = clog2(NREG), fixed 2 bits at default)
- RST_DISP, 8'h00, reset value of the display register

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_instr  input  16  instruction: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
- i_instr_valid  input  1  i_instr is valid this cycle
- o_instr_ready  output  1  block accepts an instruction this cycle
- o_data1  output  8  operand 1 to execute stage
- o_data2  output  8  operand 2 to execute stage
- o_aluOp  output  9  operation code to execute stage
- i_res  input  8  execute stage result (combinational from o_data1/o_data2/o_aluOp)
- o_disp  output  8  display register
- o_show  output  1  one-cycle pulse when o_disp is updated
- o_illegal  output  1  one-cycle pulse on undefined opcode
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- ALU op codes (numeric values): NOP = 9'd0, ADD = 9'd1, SHOW = 9'd10.
- Opcodes:
  - 0 NOP
  - 1 ADD: R[rd] = R[rd] + R[rs], 8-bit wrap, carry dropped
  - 2 SHOW: disp = R[rs]
  - 3 LDI: R[rd] = imm, issued as ADD with data1 = 0, data2 = imm
  - 4..15 illegal
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - o_instr_ready = 1.
  - On i_instr_valid = 1 (handshake): decode, register o_data1/o_data2/o_aluOp, latch rd and the opcode class, go to ISSUE.
  - No handshake: stay in IDLE, outputs hold the NOP encoding.
- ISSUE:
  - ready = 0; outputs stable for this whole cycle so the execute stage settles.
  - At the clock edge, capture i_res into a result register; go to WB.
- WB:
  - ADD/LDI: R[rd] <= captured result.
  - SHOW: o_disp <= captured result, o_show = 1 this cycle.
  - NOP/illegal: no register or display write.
  - Outputs return to NOP encoding (0, 0, 9'd0) at the WB edge; go to IDLE.
- Throughput: one instruction per 3 cycles. Accept at edge N; write visible in the register file at edge N+2; next accept possible at edge N+3.
- No hazard logic is needed: register reads occur only in IDLE, after the prior write completes.
- Operand rules:
  - ADD: data1 = R[rd], data2 = R[rs].
  - SHOW: data1 = R[rs], data2 = 0.
  - NOP/illegal: aluOp = 9'd0, data = 0.
- Illegal opcode: o_illegal pulses 1 cycle in the ISSUE state; still traverses ISSUE and WB with no side effects.
- rd == rs on ADD: the register doubles.
- i_instr_valid while not ready: ignored. The instruction is not captured; the source must hold it until the handshake completes.
- Reset (any state, including mid-instruction):
  - State = IDLE, all registers R[*] = 0, o_disp = RST_DISP.
  - o_data1 = o_data2 = 0, o_aluOp = 9'd0.
  - o_show = o_illegal = 0, o_busy = 0, o_instr_ready = 1 from the first cycle after reset.
  - An in-flight write is discarded.
- o_busy = (state != IDLE).

Decomposition:
- Shared package:
  - opcode constants OPC_NOP/ADD/SHOW/LDI (4-bit)
  - ALU op constants ALUOP_NOP = 9'd0, ALUOP_ADD = 9'd1, ALUOP_SHOW = 9'd10
  - FSM state encoding
  - instruction field positions
- One sub-module: id_regfile (NREG x 8, two async read ports, one sync write port, sync reset to 0).

Test Plan:
- Reset then LDI R1,8'h05; LDI R2,8'h03; ADD R1,R2 -> o_aluOp = 9'd1 with data1 = 05, data2 = 03 in ISSUE; R1 = 8'h08 after WB.
- LDI R0,8'hFF; LDI R3,8'h02; ADD R0,R3 -> R0 wraps to 8'h01.
- LDI R2,8'hA5; SHOW rs = R2 -> o_aluOp = 9'd10, data1 = A5 in ISSUE; o_disp = 8'hA5, o_show pulses exactly 1 cycle.
- Hold i_instr_valid high continuously with 4 instructions -> o_instr_ready high only in IDLE; handshakes 3 cycles apart; all 4 executed in order.
- Opcode 4'hF -> o_illegal 1-cycle pulse; o_aluOp = 9'd0; registers and o_disp unchanged.
- Assert i_rst during ISSUE of ADD R1,R1 (R1 = 8'h04) -> next cycle IDLE, R1 = 0, o_aluOp = 9'd0, o_disp = RST_DISP, no o_show.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared definitions for the id_issue decode/issue stage: instruction fields,
// opcodes, ALU operation codes and FSM encodings.
package id_issue_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ALUOP_W = 9;
    localparam int unsigned OPC_W   = 4;

    // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'd1;
    localparam logic [OPC_W-1:0] OPC_SHOW = 4'd2;
    localparam logic [OPC_W-1:0] OPC_LDI  = 4'd3;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP  = 9'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 9'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_SHOW = 9'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WB
    } state_t;

    // What the write-back cycle must do with the captured result
    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_WRITE,
        CLS_SHOW
    } cls_t;

endpackage

// File: rtl/id_regfile.sv
// General register file: two asynchronous read ports, one synchronous write
// port, synchronous reset of every entry to zero.
module id_regfile
    import id_issue_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREG];

    assign rdata1 = mem[ra1];
    assign rdata2 = mem[ra2];

    // Reset has priority so an in-flight write is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: accepts an instruction, drives the execute stage for one
// cycle, captures its result and writes it back to a register or the display.
module id_issue
    import id_issue_pkg::*;
#(
    parameter int unsigned       NREG     = 4,
    parameter logic [DATA_W-1:0] RST_DISP = 8'h00
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [INSTR_W-1:0]  i_instr,
    input  logic                i_instr_valid,
    output logic                o_instr_ready,
    output logic [DATA_W-1:0]   o_data1,
    output logic [DATA_W-1:0]   o_data2,
    output logic [ALUOP_W-1:0]  o_aluOp,
    input  logic [DATA_W-1:0]   i_res,
    output logic [DATA_W-1:0]   o_disp,
    output logic                o_show,
    output logic                o_illegal,
    output logic                o_busy
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    state_t              state, state_next;
    cls_t                cls_q, cls_n;
    logic [AW-1:0]       rd_q, rd_n;
    logic [DATA_W-1:0]   res_q, res_n;
    logic [DATA_W-1:0]   data1_n, data2_n, disp_n;
    logic [ALUOP_W-1:0]  aluop_n;
    logic                show_n, illegal_n, ready_n, busy_n;

    logic [OPC_W-1:0]    opc;
    logic [AW-1:0]       rd_f, rs_f, ra1;
    logic [DATA_W-1:0]   imm, rdata1, rdata2;
    logic                we;

    assign opc  = i_instr[OPC_LSB +: OPC_W];
    assign rd_f = i_instr[RD_LSB +: AW];
    assign rs_f = i_instr[RS_LSB +: AW];
    assign imm  = i_instr[IMM_LSB +: DATA_W];

    // SHOW reads rs on port 1; everything else reads rd there
    assign ra1 = (opc == OPC_SHOW) ? rs_f : rd_f;

    id_regfile #(
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk    (i_clk),
        .rst    (i_rst),
        .ra1    (ra1),
        .ra2    (rs_f),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (we),
        .wa     (rd_q),
        .wd     (res_q)
    );

    always_comb begin
        state_next = state;
        cls_n      = cls_q;
        rd_n       = rd_q;
        res_n      = res_q;
        data1_n    = o_data1;
        data2_n    = o_data2;
        aluop_n    = o_aluOp;
        disp_n     = o_disp;
        show_n     = 1'b0;
        illegal_n  = 1'b0;
        we         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_instr_valid) begin
                    state_next = ST_ISSUE;
                    rd_n       = rd_f;
                    cls_n      = CLS_NONE;
                    aluop_n    = ALUOP_NOP;
                    data1_n    = '0;
                    data2_n    = '0;
                    case (opc)
                        OPC_NOP: ;
                        OPC_ADD: begin
                            cls_n   = CLS_WRITE;
                            aluop_n = ALUOP_ADD;
                            data1_n = rdata1;
                            data2_n = rdata2;
                        end
                        OPC_SHOW: begin
                            cls_n   = CLS_SHOW;
                            aluop_n = ALUOP_SHOW;
                            data1_n = rdata1;
                        end
                        OPC_LDI: begin
                            cls_n   = CLS_WRITE;
                            aluop_n = ALUOP_ADD;
                            data2_n = imm;
                        end
                        default: illegal_n = 1'b1;
                    endcase
                end
            end
            ST_ISSUE: begin
                state_next = ST_WB;
                res_n      = i_res;
                show_n     = (cls_q == CLS_SHOW);
            end
            ST_WB: begin
                state_next = ST_IDLE;
                we         = (cls_q == CLS_WRITE);
                if (cls_q == CLS_SHOW) begin
                    disp_n = res_q;
                end
                aluop_n = ALUOP_NOP;
                data1_n = '0;
                data2_n = '0;
            end
            default: state_next = ST_IDLE;
        endcase

        ready_n = (state_next == ST_IDLE);
        busy_n  = (state_next != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            cls_q         <= CLS_NONE;
            rd_q          <= '0;
            res_q         <= '0;
            o_data1       <= '0;
            o_data2       <= '0;
            o_aluOp       <= ALUOP_NOP;
            o_disp        <= RST_DISP;
            o_show        <= 1'b0;
            o_illegal     <= 1'b0;
            o_instr_ready <= 1'b1;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_next;
            cls_q         <= cls_n;
            rd_q          <= rd_n;
            res_q         <= res_n;
            o_data1       <= data1_n;
            o_data2       <= data2_n;
            o_aluOp       <= aluop_n;
            o_disp        <= disp_n;
            o_show        <= show_n;
            o_illegal     <= illegal_n;
            o_instr_ready <= ready_n;
            o_busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_id_issue.sv
// Directed bench for id_issue: vector table of single instructions plus
// back-to-back handshake and mid-instruction reset sequences.
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  data1, data2;
    logic [8:0]  alu_op;
    logic [7:0]  res;
    logic [7:0]  disp;
    logic        show, illegal, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    id_issue #(.NREG(4), .RST_DISP(8'h00)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr       (instr),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .o_data1       (data1),
        .o_data2       (data2),
        .o_aluOp       (alu_op),
        .i_res         (res),
        .o_disp        (disp),
        .o_show        (show),
        .o_illegal     (illegal),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Execute stage stand-in
    always_comb begin
        case (alu_op)
            9'd1:    res = data1 + data2;
            9'd10:   res = data1;
            default: res = 8'h00;
        endcase
    end

    typedef struct {
        logic [15:0] instr;
        logic [8:0]  op;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        ill;
        logic        show;
        logic [1:0]  reg_idx;
        logic [7:0]  reg_val;
        logic [7:0]  disp;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the handshake edge, i.e. in the ISSUE cycle
    task automatic send(input logic [15:0] ins);
        int n;
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 10) begin
            step();
            n++;
        end
        if (n >= 10) chk("ready_timeout", 16'(instr_ready), 16'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    logic [15:0] seq [4];
    int          hs_cyc [4];

    initial begin
        vt[0]  = '{16'h3405, 9'd1,  8'h00, 8'h05, 1'b0, 1'b0, 2'd1, 8'h05, 8'h00};
        vt[1]  = '{16'h3803, 9'd1,  8'h00, 8'h03, 1'b0, 1'b0, 2'd2, 8'h03, 8'h00};
        vt[2]  = '{16'h1600, 9'd1,  8'h05, 8'h03, 1'b0, 1'b0, 2'd1, 8'h08, 8'h00};
        vt[3]  = '{16'h30FF, 9'd1,  8'h00, 8'hFF, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00};
        vt[4]  = '{16'h3C02, 9'd1,  8'h00, 8'h02, 1'b0, 1'b0, 2'd3, 8'h02, 8'h00};
        vt[5]  = '{16'h1300, 9'd1,  8'hFF, 8'h02, 1'b0, 1'b0, 2'd0, 8'h01, 8'h00};
        vt[6]  = '{16'h38A5, 9'd1,  8'h00, 8'hA5, 1'b0, 1'b0, 2'd2, 8'hA5, 8'h00};
        vt[7]  = '{16'h2200, 9'd10, 8'hA5, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA5, 8'hA5};
        vt[8]  = '{16'hF123, 9'd0,  8'h00, 8'h00, 1'b1, 1'b0, 2'd1, 8'h08, 8'hA5};
        vt[9]  = '{16'h0000, 9'd0,  8'h00, 8'h00, 1'b0, 1'b0, 2'd3, 8'h02, 8'hA5};
        vt[10] = '{16'h1F00, 9'd1,  8'h02, 8'h02, 1'b0, 1'b0, 2'd3, 8'h04, 8'hA5};
        vt[11] = '{16'h2000, 9'd10, 8'h01, 8'h00, 1'b0, 1'b1, 2'd0, 8'h01, 8'h01};

        rst         = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready",   16'(instr_ready), 16'd1);
        chk("rst_busy",    16'(busy),        16'd0);
        chk("rst_aluop",   16'(alu_op),      16'd0);
        chk("rst_disp",    16'(disp),        16'h00);
        chk("rst_show",    16'(show),        16'd0);
        chk("rst_illegal", 16'(illegal),     16'd0);

        for (int i = 0; i < 12; i++) begin
            send(vt[i].instr);
            // ISSUE cycle
            chk("issue_aluop",   16'(alu_op),      16'(vt[i].op));
            chk("issue_data1",   16'(data1),       16'(vt[i].d1));
            chk("issue_data2",   16'(data2),       16'(vt[i].d2));
            chk("issue_illegal", 16'(illegal),     16'(vt[i].ill));
            chk("issue_show",    16'(show),        16'd0);
            chk("issue_ready",   16'(instr_ready), 16'd0);
            chk("issue_busy",    16'(busy),        16'd1);
            step();
            // WB cycle
            chk("wb_show",    16'(show),    16'(vt[i].show));
            chk("wb_illegal", 16'(illegal), 16'd0);
            chk("wb_busy",    16'(busy),    16'd1);
            step();
            // back in IDLE
            chk("idle_reg",   16'(dut.u_rf.mem[vt[i].reg_idx]), 16'(vt[i].reg_val));
            chk("idle_disp",  16'(disp),        16'(vt[i].disp));
            chk("idle_show",  16'(show),        16'd0);
            chk("idle_aluop", 16'(alu_op),      16'd0);
            chk("idle_data1", 16'(data1),       16'd0);
            chk("idle_ready", 16'(instr_ready), 16'd1);
            chk("idle_busy",  16'(busy),        16'd0);
        end

        // Back-to-back: valid held high through four instructions
        seq[0] = 16'h3411;  // LDI R1,11
        seq[1] = 16'h3822;  // LDI R2,22
        seq[2] = 16'h1600;  // ADD R1,R2 -> 33
        seq[3] = 16'h2100;  // SHOW R1
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            instr = seq[k];
            n = 0;
            while (!instr_ready && n < 8) begin
                chk("b2b_busy_when_not_ready", 16'(busy), 16'd1);
                step();
                n++;
            end
            if (n >= 8) chk("b2b_ready_timeout", 16'(instr_ready), 16'd1);
            hs_cyc[k] = cyc;
            step();
            if (k > 0) chk("b2b_spacing", 16'(hs_cyc[k] - hs_cyc[k-1]), 16'd3);
        end
        instr_valid = 1'b0;
        instr       = 16'h0000;
        step();
        step();
        chk("b2b_r1",   16'(dut.u_rf.mem[1]), 16'h33);
        chk("b2b_r2",   16'(dut.u_rf.mem[2]), 16'h22);
        chk("b2b_disp", 16'(disp),            16'h33);
        chk("b2b_idle", 16'(instr_ready),     16'd1);

        // Reset during ISSUE of ADD R1,R1 discards the write
        send(16'h3404);  // LDI R1,04
        step();
        step();
        chk("pre_rst_r1", 16'(dut.u_rf.mem[1]), 16'h04);
        send(16'h1500);  // ADD R1,R1
        chk("dbl_aluop", 16'(alu_op), 16'd1);
        chk("dbl_data1", 16'(data1),  16'h04);
        chk("dbl_data2", 16'(data2),  16'h04);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy",  16'(busy),             16'd0);
        chk("mid_rst_ready", 16'(instr_ready),      16'd1);
        chk("mid_rst_aluop", 16'(alu_op),           16'd0);
        chk("mid_rst_data1", 16'(data1),            16'd0);
        chk("mid_rst_r1",    16'(dut.u_rf.mem[1]), 16'h00);
        chk("mid_rst_disp",  16'(disp),             16'h00);
        chk("mid_rst_show",  16'(show),             16'd0);
        step();
        chk("post_rst_r1",   16'(dut.u_rf.mem[1]), 16'h00);
        chk("post_rst_show", 16'(show),             16'd0);
        chk("post_rst_busy", 16'(busy),             16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
